opb_counter_bank: RTL and testbench

Parametrised bank of N_CH event counters, each CNT_WIDTH bits, readable by the PowerPC over OPB, for 10GbE TX/RX packet, error and overflow statistics. It generalises the single 32-bit software-readable register with:
- per-channel counting with wrap or saturate mode;
- atomic multi-word snapshots;
- a per-channel enable mask;
- sticky overflow flags.

It sits on the OPB bus beside the other memory-mapped registers. Event pulses come from fabric logic in the same clock domain.

---
 rtl/opb_counter_bank.sv | 170 +++++++++++++++++
 tb/tb_opb_counter_bank.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_counter_bank.sv
// opb_counter_bank: N_CH event counters with snapshot, clear, enable mask and sticky
// overflow flags behind a 32-bit OPB slave. Define OPB_COUNTER_BANK_IRQ_EN for IRQ_MASK and irq.
module opb_counter_bank #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex6",
  parameter int          N_CH         = 4,
  parameter int          CNT_WIDTH    = 48,
  parameter int          SATURATE     = 0
) (
  input  logic            OPB_Clk,
  input  logic            OPB_Rst,
  input  logic [0:31]     OPB_ABus,
  input  logic [0:3]      OPB_BE,
  input  logic [0:31]     OPB_DBus,
  input  logic            OPB_RNW,
  input  logic            OPB_select,
  input  logic            OPB_seqAddr,
  output logic [0:31]     Sl_DBus,
  output logic            Sl_xferAck,
  output logic            Sl_errAck,
  output logic            Sl_retry,
  output logic            Sl_toutSup,
  input  logic [N_CH-1:0] event_in
`ifdef OPB_COUNTER_BANK_IRQ_EN
  ,
  output logic            irq
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  if (C_OPB_DWIDTH != 32 || C_OPB_AWIDTH != 32) begin : g_bad_bus
    $error("opb_counter_bank (%s): only a 32-bit OPB is supported", C_FAMILY);
  end
  if (N_CH < 1 || N_CH > 16 || CNT_WIDTH < 33 || CNT_WIDTH > 64) begin : g_bad_size
    $error("opb_counter_bank: N_CH must be 1..16 and CNT_WIDTH 33..64");
  end

  // Big-endian OPB vectors map straight onto little-endian values: OPB bit 31 is value bit 0.
  logic [31:0] addr, wdata, offset, high_diff;
  logic [3:0]  be;
  logic [29:0] word;
  logic        below_base, above_high;
  logic        hit, xfer, wr;

  assign addr  = OPB_ABus;
  assign wdata = OPB_DBus;
  assign be    = OPB_BE;

  // Range checks via borrow bits so a zero base address needs no special casing.
  assign {below_base, offset}    = {1'b0, addr} - {1'b0, C_BASEADDR};
  assign {above_high, high_diff} = {1'b0, C_HIGHADDR} - {1'b0, addr};
  assign word = offset[31:2];

  logic ack_q;
  logic [31:0] dbus_q, rdata;

  assign hit  = OPB_select && !below_base && !above_high;
  assign xfer = hit && !ack_q;
  assign wr   = xfer && !OPB_RNW;

  logic [N_CH-1:0] lane_mask;
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    assign lane_mask[i] = be[i/8];
  end

  logic snap, clr, wr_ovf, wr_en;
  assign snap   = wr && (word == 30'd0) && be[0] && wdata[0];
  assign clr    = wr && (word == 30'd0) && be[0] && wdata[1];
  assign wr_ovf = wr && (word == 30'd1);
  assign wr_en  = wr && (word == 30'd2);

  logic [N_CH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d, snap_q;
  logic [N_CH-1:0] ovf_q, ovf_d, ovf_set, ovf_w1c, en_q, en_d, inc;

  assign inc = event_in & en_q;

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (clr) begin
        cnt_d[i] = '0;
      end else if (inc[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_set[i] = 1'b1;
          cnt_d[i]   = (SATURATE != 0) ? CNT_MAX : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // A flag being set wins over a software clear in the same cycle.
  assign ovf_w1c = wr_ovf ? (wdata[N_CH-1:0] & lane_mask) : '0;
  assign ovf_d   = (ovf_q & ~ovf_w1c) | ovf_set;
  assign en_d    = wr_en ? ((en_q & ~lane_mask) | (wdata[N_CH-1:0] & lane_mask)) : en_q;

`ifdef OPB_COUNTER_BANK_IRQ_EN
  logic [N_CH-1:0] mask_q;
  logic            irq_q, wr_mask;

  assign wr_mask = wr && (word == 30'd3);
  assign irq     = irq_q;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_mask) mask_q <= (mask_q & ~lane_mask) | (wdata[N_CH-1:0] & lane_mask);
      irq_q <= |(ovf_q & mask_q);
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (word)
      30'd0: rdata = {8'(N_CH), 8'(CNT_WIDTH), 16'h0000};
      30'd1: rdata = 32'(ovf_q);
      30'd2: rdata = 32'(en_q);
`ifdef OPB_COUNTER_BANK_IRQ_EN
      30'd3: rdata = 32'(mask_q);
`endif
      default: begin
        for (int i = 0; i < N_CH; i++) begin
          if (word == 30'(4 + 2*i)) rdata = 32'(snap_q[i]);
          if (word == 30'(5 + 2*i)) rdata = 32'(snap_q[i] >> 32);
        end
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      ack_q  <= 1'b0;
      dbus_q <= '0;
      cnt_q  <= '0;
      // NOTE: snapshots are reset like any register since software may read them before any strobe.
      snap_q <= '0;
      ovf_q  <= '0;
      en_q   <= '1;
    end else begin
      ack_q  <= xfer;
      dbus_q <= (xfer && OPB_RNW) ? rdata : '0;
      cnt_q  <= cnt_d;
      if (snap) snap_q <= cnt_q;
      ovf_q  <= ovf_d;
      en_q   <= en_d;
    end
  end

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, offset[1:0], high_diff, wdata, be};

endmodule

// File: tb/tb_opb_counter_bank.sv
// Directed bench for opb_counter_bank: a wrap-mode and a saturate-mode instance share one OPB
// master and event source; register-map vectors come from a table, corner cases are sequences.
`timescale 1ns/1ps
module tb_opb_counter_bank;

  localparam int N_CH = 4;
  localparam int CW   = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [0:31]     abus, dbus_w;
  logic [0:3]      be;
  logic            rnw, sel, seq_addr;
  logic [N_CH-1:0] ev;
  logic [0:31]     rd_w, rd_s;
  logic            ack_w, ack_s, err_w, err_s, rty_w, rty_s, tout_w, tout_s;
`ifdef OPB_COUNTER_BANK_IRQ_EN
  logic            irq_w, irq_s;
`endif

  opb_counter_bank #(.N_CH(N_CH), .CNT_WIDTH(CW), .SATURATE(0)) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_w),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq_addr),
    .Sl_DBus(rd_w), .Sl_xferAck(ack_w), .Sl_errAck(err_w), .Sl_retry(rty_w),
    .Sl_toutSup(tout_w), .event_in(ev)
`ifdef OPB_COUNTER_BANK_IRQ_EN
    , .irq(irq_w)
`endif
  );

  opb_counter_bank #(.N_CH(N_CH), .CNT_WIDTH(CW), .SATURATE(1)) dut_sat (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_w),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq_addr),
    .Sl_DBus(rd_s), .Sl_xferAck(ack_s), .Sl_errAck(err_s), .Sl_retry(rty_s),
    .Sl_toutSup(tout_s), .event_in(ev)
`ifdef OPB_COUNTER_BANK_IRQ_EN
    , .irq(irq_s)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One OPB transfer; ev_req is applied only in the request cycle.
  task automatic bus(input string n, input logic [31:0] a, input logic r, input logic [31:0] d,
                     input logic [3:0] b, input logic [N_CH-1:0] ev_req,
                     output logic [31:0] q_w, output logic [31:0] q_s);
    int lat;
    @(negedge clk);
    abus = a; rnw = r; dbus_w = d; be = b; sel = 1'b1; ev = ev_req;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      ev = '0;
    end while (!ack_w && lat < 4);
    check({n, " ack latency"}, 64'(lat), 64'd1);
    check({n, " ack sat"}, 64'(ack_s), 64'd1);
    q_w = rd_w;
    q_s = rd_s;
    sel = 1'b0; rnw = 1'b1; dbus_w = '0;
  endtask

  task automatic rd(input string n, input logic [31:0] a, input logic [31:0] ew, input logic [31:0] es);
    logic [31:0] qw, qs;
    bus(n, a, 1'b1, 32'h0, 4'hF, '0, qw, qs);
    check({n, " wrap"}, 64'(qw), 64'(ew));
    check({n, " sat"}, 64'(qs), 64'(es));
  endtask

  task automatic wr(input string n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] qw, qs;
    bus(n, a, 1'b0, d, b, '0, qw, qs);
  endtask

  // Preload channel counters in both instances while one event is pending.
  task automatic preload(input logic [N_CH*CW-1:0] val, input logic [N_CH-1:0] ev_now);
    @(negedge clk);
    force dut.cnt_q = val;
    force dut_sat.cnt_q = val;
    ev = ev_now;
    #1;
    release dut.cnt_q;
    release dut_sat.cnt_q;
    @(negedge clk);
    ev = '0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rnw;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string n, input logic [31:0] a, input logic r,
                         input logic [31:0] d, input logic [3:0] b, input logic [31:0] e);
    vec_t v;
    v.name = n; v.addr = a; v.rnw = r; v.wdata = d; v.be = b; v.exp = e;
    vecs.push_back(v);
  endtask

`ifdef OPB_COUNTER_BANK_IRQ_EN
  localparam logic [31:0] MASK_RB = 32'h3;
`else
  localparam logic [31:0] MASK_RB = 32'h0;
`endif

  localparam logic [CW-1:0] ONES = '1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] qw, qs;

    abus = '0; dbus_w = '0; be = '0; rnw = 1'b1; sel = 1'b0; seq_addr = 1'b0; ev = '0;

    add_vec("rd ctrl",        32'h00, 1'b1, 32'h0,        4'hF, 32'h0430_0000);
    add_vec("rd ovf",         32'h04, 1'b1, 32'h0,        4'hF, 32'h0);
    add_vec("rd enable",      32'h08, 1'b1, 32'h0,        4'hF, 32'hF);
    add_vec("rd mask",        32'h0C, 1'b1, 32'h0,        4'hF, 32'h0);
    add_vec("rd snap0 lo",    32'h10, 1'b1, 32'h0,        4'hF, 32'h0);
    add_vec("rd snap3 hi",    32'h2C, 1'b1, 32'h0,        4'hF, 32'h0);
    add_vec("rd unmapped",    32'h30, 1'b1, 32'h0,        4'hF, 32'h0);
    add_vec("rd top of win",  32'hFC, 1'b1, 32'h0,        4'hF, 32'h0);
    add_vec("wr en no be",    32'h08, 1'b0, 32'h0,        4'h0, 32'h0);
    add_vec("rd en no be",    32'h08, 1'b1, 32'h0,        4'hF, 32'hF);
    add_vec("wr en lane0",    32'h08, 1'b0, 32'h5,        4'h1, 32'h0);
    add_vec("rd en lane0",    32'h08, 1'b1, 32'h0,        4'hF, 32'h5);
    add_vec("wr en ones",     32'h08, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0);
    add_vec("rd en ones",     32'h08, 1'b1, 32'h0,        4'hF, 32'hF);
    add_vec("wr mask",        32'h0C, 1'b0, 32'h3,        4'hF, 32'h0);
    add_vec("rd mask wr",     32'h0C, 1'b1, 32'h0,        4'hF, MASK_RB);
    add_vec("wr mask zero",   32'h0C, 1'b0, 32'h0,        4'hF, 32'h0);
    add_vec("rd mask zero",   32'h0C, 1'b1, 32'h0,        4'hF, 32'h0);
    add_vec("wr unmapped",    32'h30, 1'b0, 32'hFFFF,     4'hF, 32'h0);
    add_vec("rd unmapped wr", 32'h30, 1'b1, 32'h0,        4'hF, 32'h0);

    // Reset state, with a request pending to show no ack leaks out of reset.
    repeat (2) @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    check("reset ack", 64'({ack_w, ack_s}), 64'd0);
    check("reset dbus", 64'({rd_w, rd_s}), 64'd0);
    check("reset tied outputs", 64'({err_w, rty_w, tout_w, err_s, rty_s, tout_s}), 64'd0);
`ifdef OPB_COUNTER_BANK_IRQ_EN
    check("reset irq", 64'({irq_w, irq_s}), 64'd0);
`endif
    sel = 1'b0;
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      bus(vecs[k].name, vecs[k].addr, vecs[k].rnw, vecs[k].wdata, vecs[k].be, '0, qw, qs);
      if (vecs[k].rnw) begin
        check({vecs[k].name, " wrap"}, 64'(qw), 64'(vecs[k].exp));
        check({vecs[k].name, " sat"}, 64'(qs), 64'(vecs[k].exp));
      end
    end

    // Read data must drop back to zero once the ack cycle is over.
    bus("rd ctrl again", 32'h00, 1'b1, 32'h0, 4'hF, '0, qw, qs);
    @(negedge clk);
    check("dbus after ack", 64'({rd_w, rd_s}), 64'd0);

    // 1000 single-cycle pulses on channel 2.
    wr("clear", 32'h00, 32'h2, 4'hF);
    repeat (1000) begin
      @(negedge clk); ev = 4'b0100;
      @(negedge clk); ev = '0;
    end
    wr("ctrl without lane", 32'h00, 32'h3, 4'hE);
    rd("snap2 untouched", 32'h20, 32'h0, 32'h0);
    wr("snapshot", 32'h00, 32'h1, 4'hF);
    rd("snap2 lo 1000", 32'h20, 32'h3E8, 32'h3E8);
    rd("snap2 hi 1000", 32'h24, 32'h0, 32'h0);
    rd("snap0 idle", 32'h10, 32'h0, 32'h0);

    // Enable mask: channel 2 disabled for 10 cycles of all-ones events.
    wr("clear", 32'h00, 32'h2, 4'hF);
    wr("enable 0xB", 32'h08, 32'hB, 4'hF);
    @(negedge clk); ev = 4'hF;
    repeat (10) @(negedge clk);
    ev = '0;
    wr("snapshot", 32'h00, 32'h1, 4'hF);
    rd("mask snap0", 32'h10, 32'd10, 32'd10);
    rd("mask snap1", 32'h18, 32'd10, 32'd10);
    rd("mask snap2", 32'h20, 32'd0, 32'd0);
    rd("mask snap3", 32'h28, 32'd10, 32'd10);
    wr("enable all", 32'h08, 32'hF, 4'hF);

    // Channel 1 at all-ones with one pending event: wrap vs saturate.
    wr("clear", 32'h00, 32'h2, 4'hF);
    preload({{CW{1'b0}}, {CW{1'b0}}, ONES, {CW{1'b0}}}, 4'b0010);
    wr("snapshot", 32'h00, 32'h1, 4'hF);
    rd("ovf snap1 lo", 32'h18, 32'h0, 32'hFFFF_FFFF);
    rd("ovf snap1 hi", 32'h1C, 32'h0, 32'h0000_FFFF);
    rd("ovf flags", 32'h04, 32'h2, 32'h2);
    wr("w1c no lane", 32'h04, 32'h2, 4'h0);
    rd("ovf kept", 32'h04, 32'h2, 32'h2);
    wr("w1c", 32'h04, 32'h2, 4'h1);
    rd("ovf cleared", 32'h04, 32'h0, 32'h0);
    @(negedge clk); ev = 4'b0010;
    @(negedge clk); ev = '0;
    rd("ovf at max again", 32'h04, 32'h0, 32'h2);
    bus("w1c with event", 32'h04, 1'b0, 32'h2, 4'hF, 4'b0010, qw, qs);
    rd("ovf set wins", 32'h04, 32'h0, 32'h2);
    wr("w1c all", 32'h04, 32'hF, 4'hF);
    rd("ovf all clear", 32'h04, 32'h0, 32'h0);

    // Snapshot and clear together while channel 0 holds 5 and sees an event.
    wr("clear", 32'h00, 32'h2, 4'hF);
    @(negedge clk); ev = 4'b0001;
    repeat (5) @(negedge clk);
    ev = '0;
    bus("snap+clear", 32'h00, 1'b0, 32'h3, 4'hF, 4'b0001, qw, qs);
    rd("snap+clear snap0", 32'h10, 32'd5, 32'd5);
    wr("snapshot", 32'h00, 32'h1, 4'hF);
    rd("post clear snap0", 32'h10, 32'd0, 32'd0);
    rd("post clear snap1", 32'h18, 32'd0, 32'd0);

`ifdef OPB_COUNTER_BANK_IRQ_EN
    wr("mask ch0", 32'h0C, 32'h1, 4'hF);
    preload({{CW{1'b0}}, {CW{1'b0}}, {CW{1'b0}}, ONES}, 4'b0001);
    check("irq not yet", 64'({irq_w, irq_s}), 64'd0);
    @(negedge clk);
    check("irq raised", 64'({irq_w, irq_s}), 64'd3);
    wr("w1c ch0", 32'h04, 32'h1, 4'hF);
    check("irq at w1c ack", 64'({irq_w, irq_s}), 64'd3);
    @(negedge clk);
    check("irq dropped", 64'({irq_w, irq_s}), 64'd0);
    wr("mask off", 32'h0C, 32'h0, 4'hF);
`endif

    // Just past the window: never acknowledged.
    @(negedge clk);
    abus = 32'h100; rnw = 1'b1; sel = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no ack outside window", 64'({ack_w, ack_s}), 64'd0);
    end
    sel = 1'b0;

    // Reset arriving with a transfer request aborts it and restores defaults.
    wr("enable 0x3", 32'h08, 32'h3, 4'hF);
    @(negedge clk);
    abus = 32'h08; rnw = 1'b1; sel = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("reset mid transfer ack", 64'({ack_w, ack_s}), 64'd0);
    rst = 1'b0; sel = 1'b0;
    rd("enable after reset", 32'h08, 32'hF, 32'hF);
    rd("snap0 after reset", 32'h10, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
